triangle_stream_buffer: RTL

Parametrised successor to the on-chip triangle list memory. It stores packed 3D triangles (3 vertices × x,y,z) in a circular on-chip buffer and moves them in and out through valid/ready handshakes instead of raw address ports.
It has two run-time modes:
- FIFO mode: each triangle is consumed once.
- REPLAY mode: the stored list is retained and re-streamed in full on every r_start, for example once per frame to the transform/raster pipeline.

---
 rtl/triangle_stream_buffer.sv | 138 +++++++++++++
 1 files changed

// File: rtl/triangle_stream_buffer.sv
// Circular on-chip triangle store with valid/ready write and read ports.
// FIFO mode consumes each entry once; REPLAY mode re-streams the stored list on every r_start.
module triangle_stream_buffer #(
  parameter int WI    = 8,
  parameter int WF    = 8,
  parameter int DEPTH = 100,
  parameter int Waddr = 7,
  parameter int DW    = (WI + WF) * 9
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             clear,
  input  logic             mode,
  input  logic             w_valid,
  output logic             w_ready,
  input  logic [DW-1:0]    w_data,
  input  logic             r_start,
  output logic             r_valid,
  input  logic             r_ready,
  output logic [DW-1:0]    r_data,
  output logic             r_last,
  output logic             r_done,
  output logic [Waddr:0]   count,
  output logic             is_empty,
  output logic             is_full,
  output logic [1:0]       fsm_state
);

  // Handshakes: a transfer happens on a rising Clk edge where valid && ready;
  // r_data/r_valid/r_last hold stable while r_valid && !r_ready. DEPTH must not exceed 2**Waddr.
  typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1, DONE = 2'd2} state_t;

  localparam logic [Waddr:0]   DEPTH_C  = (Waddr + 1)'(DEPTH);
  localparam logic [Waddr-1:0] LAST_PTR = Waddr'(DEPTH - 1);

  state_t             state;
  logic               mode_q;
  logic [Waddr-1:0]   wptr;
  logic [Waddr-1:0]   rptr;
  logic [Waddr:0]     idx;
  logic [Waddr-1:0]   rd_addr;
  logic               wr_hs;
  logic               rd_hs;
  logic               src_avail;
  logic               load_ok;
  logic [DW-1:0]      mem [DEPTH];

  function automatic logic [Waddr-1:0] ptr_inc(input logic [Waddr-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign is_empty  = (count == '0);
  assign is_full   = (count == DEPTH_C);
  assign w_ready   = !is_full && (!mode_q || state == IDLE);
  assign wr_hs     = w_valid && w_ready;
  assign rd_hs     = r_valid && r_ready;
  assign fsm_state = state;

  // FIFO: entries not yet pulled into the output register; REPLAY: rest of the pass.
  always_comb begin
    src_avail = 1'b0;
    rd_addr   = rptr;
    if (!mode_q) begin
      src_avail = count > {{Waddr{1'b0}}, r_valid};
    end else begin
      src_avail = (state == STREAM) && (idx < count);
      rd_addr   = idx[Waddr-1:0];
    end
  end

  assign load_ok = (!r_valid || r_ready) && src_avail;

  always_ff @(posedge Clk) begin
    if (!Reset && !clear && wr_hs) mem[wptr] <= w_data;
  end

  always_ff @(posedge Clk) begin
    if (Reset || clear) begin
      wptr    <= '0;
      rptr    <= '0;
      idx     <= '0;
      count   <= '0;
      state   <= IDLE;
      mode_q  <= mode;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (wr_hs) wptr <= ptr_inc(wptr);

      if (!mode_q) begin
        case ({wr_hs, rd_hs})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end else if (wr_hs) begin
        count <= count + 1'b1;
      end

      if (load_ok) begin
        r_data  <= mem[rd_addr];
        r_valid <= 1'b1;
        r_last  <= mode_q && (idx == count - 1'b1);
        if (!mode_q) rptr <= ptr_inc(rptr);
        else         idx  <= idx + 1'b1;
      end else if (rd_hs) begin
        r_valid <= 1'b0;
        r_last  <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (mode_q && r_start) begin
            if (count != '0) begin
              state <= STREAM;
              idx   <= '0;
            end else begin
              state  <= DONE;
              r_done <= 1'b1;
            end
          end
        end
        STREAM: begin
          if (rd_hs && r_last) begin
            state  <= DONE;
            r_done <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
